// File: rtl/spi_slave.sv
// SPI slave front end for the SPI RAM: deserialises 10-bit command frames and serialises read data on MISO.
// Optional sticky abort flag output frame_err is enabled with `define SPI_SLAVE_FRAME_ERR_EN.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXC_W   = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-2:0]   shift;
  logic [FRAME_W-1:0]   shift_nxt;
  logic                 rd_addr_flag;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic [TXC_W-1:0]     tx_cnt;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 frame_done;
  logic                 shift_en;
  logic                 last_bit;

  assign frame_done = (bit_cnt == CNT_W'(FRAME_W));
  assign shift_en   = !SS_n && (state != IDLE) && !frame_done;
  assign last_bit   = shift_en && (bit_cnt == CNT_W'(FRAME_W - 1));
  assign shift_nxt  = {shift, MOSI};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The first frame bit plus the read-address flag select the frame type.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!SS_n) next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              next_state = IDLE;
        else if (!MOSI)        next_state = WRITE;
        else if (rd_addr_flag) next_state = READ_DATA;
        else                   next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || SS_n) begin
        bit_cnt <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
        MISO    <= 1'b0;
      end else begin
        if (shift_en) begin
          shift   <= shift_nxt[FRAME_W-2:0];
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (last_bit) begin
          rx_data  <= shift_nxt;
          rx_valid <= 1'b1;
          if (state == READ_ADD) rd_addr_flag <= 1'b1;
        end
        // Read data is accepted only once the command frame has been handed to the RAM.
        if (state == READ_DATA && frame_done) begin
          if (!tx_busy && !tx_done && tx_valid) begin
            MISO     <= tx_data[ADDR_SIZE-1];
            tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
            tx_cnt   <= TXC_W'(ADDR_SIZE - 1);
            tx_busy  <= 1'b1;
          end else if (tx_busy) begin
            if (tx_cnt == '0) begin
              MISO         <= 1'b0;
              tx_busy      <= 1'b0;
              tx_done      <= 1'b1;
              rd_addr_flag <= 1'b0;
            end else begin
              MISO     <= tx_shift[ADDR_SIZE-1];
              tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
              tx_cnt   <= tx_cnt - TXC_W'(1);
            end
          end
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (SS_n) begin
      if (((state == WRITE || state == READ_ADD || state == READ_DATA) && !frame_done) ||
          (state == READ_DATA && frame_done && !tx_done))
        frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the driver queues per-edge expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       miso;
    logic       rxv;
    logic [9:0] rx;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic       e_miso = 1'b0;
  logic       e_rxv  = 1'b0;
  logic [9:0] e_rx   = 10'h0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Queue the outputs expected after this edge, then let the edge happen.
  task automatic tick(input logic r, input logic ss, input logic mosi,
                      input logic txv, input logic [7:0] txd);
    exp_t t;
    rst_n = r; SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    if (!r) begin
      e_rx = 10'h0; e_miso = 1'b0; e_rxv = 1'b0;
    end
    t.miso = e_miso; t.rxv = e_rxv; t.rx = e_rx;
    exp_q.push_back(t);
    e_rxv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Edge 0 plus n data bits, MSB first; tx_valid/tx_data held at the given values throughout.
  task automatic send_bits(input logic [9:0] f, input int n, input logic txv, input logic [7:0] txd);
    tick(1'b1, 1'b0, 1'b0, txv, txd);
    for (int i = 0; i < n; i++) begin
      if (i == 9) begin
        e_rxv = 1'b1; e_rx = f;
      end
      tick(1'b1, 1'b0, f[9-i], txv, txd);
    end
  endtask

  // RAM answers with d; expect d MSB first on MISO, then MISO low and a late tx_valid ignored.
  task automatic miso_out(input logic [7:0] d);
    e_miso = d[7];
    tick(1'b1, 1'b0, 1'b0, 1'b1, d);
    for (int i = 6; i >= 0; i--) begin
      e_miso = d[i];
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    e_miso = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("miso",     {9'h0, MISO},     {9'h0, mon_e.miso});
      check("rx_valid", {9'h0, rx_valid}, {9'h0, mon_e.rxv});
      check("rx_data",  rx_data,          mon_e.rx);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    // Reset for two cycles, then idle with SS_n high.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(5);

    // Write address 0x0A5.
    send_bits(10'h0A5, 10, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);

    // Read address sets the flag.
    send_bits(10'h23C, 10, 1'b0, 8'h00);
    idle(2);

    // Read data: early tx_valid ignored, RAM returns C3 one cycle after rx_valid.
    send_bits(10'h300, 10, 1'b1, 8'hFF);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    miso_out(8'hC3);
    idle(2);

    // Flag cleared: 11 command takes the read-address path, no MISO activity.
    send_bits(10'h355, 10, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);

`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("frame_err_clear", {9'h0, frame_err}, 10'h0);
`endif
    // Abort after 6 bits: nothing delivered, flag untouched.
    send_bits(10'h0F3, 6, 1'b0, 8'h00);
    idle(2);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("frame_err_set", {9'h0, frame_err}, 10'h001);
`endif
    send_bits(10'h15A, 10, 1'b0, 8'h00);
    idle(1);

    // Flag still set from the 0x355 frame, so this is a read-data frame.
    send_bits(10'h301, 10, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    miso_out(8'h5A);
    idle(2);

    // Set the flag, then reset at edge 5 of a write frame.
    send_bits(10'h207, 10, 1'b0, 8'h00);
    idle(1);
    send_bits(10'h196, 4, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);

    // Reset cleared the flag: read-address path, tx_valid ignored.
    send_bits(10'h3FF, 10, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h81);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(1);
    send_bits(10'h196, 10, 1'b0, 8'h00);
    idle(3);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial front end of the SPI RAM. Deserialises 10-bit MOSI frames (2-bit command + 8-bit payload) into parallel words for the RAM's `din`/`rx_valid` inputs. On read-data commands it takes the RAM's `dout`/`tx_valid` result and serialises it back onto MISO. The FSM tracks whether a read address has been loaded.

## Interface
- `ADDR_SIZE`, default 8: RAM payload width; frame width is `ADDR_SIZE+2`.
- `clk`  in  1  SPI clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `SS_n`  in  1  slave select, active low; frame delimiter.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial read data, MSB first.
- `rx_data`  out  `ADDR_SIZE+2`  frame to RAM `din`; `[ADDR_SIZE+1:ADDR_SIZE]` = command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data).
- `rx_valid`  out  1  one-cycle strobe; `rx_data` valid.
- `tx_data`  in  `ADDR_SIZE`  RAM `dout`.
- `tx_valid`  in  1  RAM read data valid.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal `rd_addr_flag`, reset 0. Set on completion of a READ_ADD frame. Cleared on completion of a READ_DATA frame (after the last MISO bit).
- IDLE:
  - `SS_n`=0 → CHK_CMD.
  - Otherwise stay; bit counter = 0.
- CHK_CMD: MOSI (frame bit 9) is shifted in as bit 1 of the frame.
  - MOSI=0 → WRITE.
  - MOSI=1 and flag=0 → READ_ADD.
  - MOSI=1 and flag=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in the remaining 9 bits, one per edge with `SS_n`=0.
  - After bit 10, `rx_data` ← shift register and `rx_valid`=1 for exactly one cycle.
  - WRITE and READ_ADD then hold (shifting nothing) until `SS_n`=1.
- READ_DATA, after `rx_valid`:
  - Wait for `tx_valid`=1 and latch `tx_data`.
  - Drive `ADDR_SIZE` bits on MISO, MSB first, one per cycle.
  - MISO returns to 0 after the last bit.
  - `tx_valid` arriving before `rx_valid` is ignored.
- `SS_n`=1 sampled in any non-IDLE state → IDLE on that edge.
  - Counter clears, partial frame discarded, no `rx_valid`, MISO=0, flag unchanged.
  - A bit is sampled only when `SS_n`=0 on the same edge.
- Reset mid-frame: all state cleared; the frame is lost.

## Timing
- Reset values: `MISO`=0, `rx_valid`=0, `rx_data`=0, state IDLE, flag 0.
- Frame: edge 0 IDLE→CHK_CMD (no data), edges 1–10 data bits.
- `rx_data` and `rx_valid` are registered and asserted in the cycle after edge 10.
- `rx_data` holds until the next frame completes.
- MISO bit `ADDR_SIZE-1` is valid the cycle after `tx_valid` is sampled. Subsequent bits follow each cycle.
- Minimum `SS_n`-low duration:
  - Write / read-address: 11 cycles.
  - Read data: 11 + RAM latency + `ADDR_SIZE` cycles.
- `tx_valid` coincident with `SS_n`=1: ignored.

## Configuration
- `SPI_SLAVE_FRAME_ERR_EN` defined:
  - Adds output `frame_err` (1 bit). Sticky; set when `SS_n` rises after CHK_CMD but before `rx_valid`, or before the last MISO bit in READ_DATA.
  - Cleared only by `rst_n`.
- Not defined: port absent; aborted frames are dropped silently.

## Test plan
- Reset held 2 cycles, then released with `SS_n`=1 → MISO=0, `rx_valid`=0, state IDLE for 5 cycles.
- Write-address frame 00_1010_0101 → `rx_data`=10'h0A5, `rx_valid` high exactly 1 cycle after edge 10.
- Read-address 10_0011_1100, then new frame 11_0000_0000, RAM returns `tx_data`=8'hC3 with `tx_valid` → second frame enters READ_DATA, `rx_data`=10'h300, MISO=1,1,0,0,0,0,1,1, flag cleared after.
- Frame 11_xxxx with flag=0 → READ_ADD path taken, no MISO activity.
- `SS_n` raised after 6 bits → no `rx_valid`, IDLE next edge, next full frame captured correctly; with macro, `frame_err`=1.
- `rst_n` low at edge 5 of a write frame → outputs at reset values, flag 0, subsequent frame decoded normally.
